ov7670_video_source: RTL
========================

# ov7670_video_source

Synthesizable OV7670 pixel-bus transmitter: generates PCLK, VSYNC, HREF and D[7:0] with OV7670 VGA RGB565 timing, carrying selectable test patterns. It is the transmit end of the camera video interface whose receive end is the camera capture path (STROBE/HREF/PCLK/VSYNC/D pins). It drives that path in simulation and on-board loopback without a physical sensor, and doubles as the golden stimulus for capture verification.

## Interface
- CLK_DIV, 1: clk cycles per PCLK half-period (PCLK = clk / (2·CLK_DIV)); ≥1
- H_ACTIVE, 640: active pixels per line; multiple of 8
- H_BLANK, 288: HREF-low PCLK periods (tp) per line
- V_SYNC, 3: lines with VSYNC high
- V_BACK, 17: blank lines after VSYNC
- V_ACTIVE, 480: active lines
- V_FRONT, 10: blank lines after active region
- clk  input  1  system clock
- reset_  input  1  asynchronous, active-low reset
- enable  input  1  frame generation request, sampled at frame boundary
- pattern_sel  input  2  0 colour bars, 1 ramp, 2 frame-count solid, 3 checkerboard
- pclk  output  1  pixel clock
- vsync  output  1  frame sync, active high
- href  output  1  line valid, active high
- d  output  8  pixel byte
- frame_done  output  1  one-clk pulse at end of each frame
- frame_cnt  output  8  completed-frame count, wraps 255→0

## Operation
- Line = LINE_TP = 2·H_ACTIVE + H_BLANK tp; every line in every state has this length.
- States: IDLE → VSYNC (V_SYNC lines, vsync=1) → VBACK (V_BACK lines) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines) → VSYNC if enable=1, else IDLE.
- IDLE → VSYNC at the first pclk falling edge where enable=1.
- pattern_sel latched on entry to VSYNC; held for whole frame.
- ACTIVE line: href=1 for first 2·H_ACTIVE tp, then 0 for H_BLANK tp. href=0 in all other states.
- Two bytes per pixel, high byte first: byte0 = P[15:8], byte1 = P[7:0]. d=0 whenever href=0.
- x = pixel index in line (0..H_ACTIVE-1), y = active line index.
- Pattern 0: 8 bars, width H_ACTIVE/8 px (bar counter, no divider): FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
- Pattern 1: P = x (16-bit, zero-extended).
- Pattern 2: P = {frame_cnt, frame_cnt}.
- Pattern 3: P = (x[3] ^ y[3]) ? FFFF : 0000.
- Last tp of VFRONT ends: frame_done=1 for one clk, frame_cnt increments same cycle.
- enable deasserted mid-frame: current frame completes fully, then IDLE. Reasserted before frame end: next frame starts with no gap.
- pclk toggles continuously out of reset regardless of enable/state.

## Timing
- Reset (async assert, no clock needed): pclk=0, vsync=0, href=0, d=0, frame_done=0, frame_cnt=0, state IDLE, all counters 0.
- After reset release: pclk first rises CLK_DIV clks later, then toggles every CLK_DIV clks.
- vsync, href, d are registered and change only in the clk cycle where pclk falls; stable across every pclk rising edge (receiver samples on rise).
- Frame = (V_SYNC+V_BACK+V_ACTIVE+V_FRONT)·LINE_TP tp, exact, back to back.
- vsync high exactly V_SYNC·LINE_TP tp; first href rise exactly V_BACK·LINE_TP tp after vsync falls.
- frame_done coincides with the pclk falling edge ending the frame; the next frame's vsync rises on that same edge.
- Reset mid-frame: immediate return to reset values; a fresh frame begins with a full VSYNC.

## Test plan
Common params: CLK_DIV=1, H_ACTIVE=8, H_BLANK=4, V_SYNC=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1 → LINE_TP=20 tp, frame=100 tp=200 clk.
- Reset, enable=0: all outputs 0 during reset; after release pclk toggles every clk; vsync/href/d stay 0 for 300 clk; frame_done never pulses.
- enable=1, pattern 0: vsync high 20 tp; href rises 20 tp after vsync falls; two 16-tp href pulses separated by 4 tp; each line d = FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
- Pattern 1: each active line d = 00 00 00 01 00 02 00 03 00 04 00 05 00 06 00 07.
- Pattern 2, two frames: frame 1 active bytes all 00, frame 2 all 01; frame_done pulses exactly 200 clk apart; frame_cnt 0→1→2.
- Change pattern_sel 0→1 and drop enable during frame 1 ACTIVE: frame 1 stays colour bars to completion, frame_done pulses, then vsync stays 0.
- Assert reset_ low mid-active-line with clk stopped: outputs 0 immediately; on release with enable=1, vsync high for full 20 tp before any href.

Source files
------------

// File: rtl/ov7670_video_source_if.sv
// ov7670_video_source_if
//
// Purpose: the OV7670 parallel pixel bus between a video source and a
// capture path. The source drives every signal; the receiver samples
// vsync, href and d on the rising edge of pclk.
//
// Signals:
//   pclk   pixel clock
//   vsync  frame sync, active high
//   href   line valid, active high
//   d      pixel byte (high byte of each RGB565 pixel first)
//
// Modports:
//   master  driven by the video source
//   slave   observed by the capture path
interface ov7670_video_source_if;
    logic       pclk;
    logic       vsync;
    logic       href;
    logic [7:0] d;

    modport master (output pclk, output vsync, output href, output d);
    modport slave  (input  pclk, input  vsync, input  href, input  d);
endinterface

// File: rtl/ov7670_video_source.sv
// ov7670_video_source
//
// Purpose: OV7670 pixel-bus transmitter. Generates pclk, vsync, href and d
// with VGA RGB565 style timing and carries one of four test patterns, so a
// capture path can be exercised without a physical sensor.
//
// Ports:
//   clk          system clock
//   reset_       asynchronous active-low reset
//   enable       frame request, sampled at frame boundaries
//   pattern_sel  0 colour bars, 1 ramp, 2 frame-count solid, 3 checkerboard
//   cam          pixel bus (master side): pclk, vsync, href, d
//   frame_done   one-clk pulse on the pclk fall that ends a frame
//   frame_cnt    completed-frame count, wraps 255 -> 0
module ov7670_video_source #(
    parameter int CLK_DIV  = 1,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 288,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         enable,
    input  logic [1:0]                   pattern_sel,
    ov7670_video_source_if.master        cam,
    output logic                         frame_done,
    output logic [7:0]                   frame_cnt
);

    localparam int LINE_TP = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    // At least 5 bits of line position and 4 bits of line index so that the
    // checkerboard can always look at x[3] (= h[4]) and y[3].
    localparam int HW      = ($clog2(LINE_TP) < 5) ? 5 : $clog2(LINE_TP);
    localparam int VW      = ($clog2(V_TOTAL) < 4) ? 4 : $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BAR_PX  = H_ACTIVE / 8;
    localparam int BW      = (BAR_PX > 1) ? $clog2(BAR_PX) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(LINE_TP - 1);
    localparam logic [HW-1:0] H_HREF   = HW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_PX - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic           pclk_q, pclk_d;
    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [BW-1:0]  bar_px_q, bar_px_d;
    logic [2:0]     bar_idx_q, bar_idx_d;
    logic [1:0]     pat_q, pat_d;
    logic           vsync_q, vsync_d;
    logic           href_q, href_d;
    logic [7:0]     d_q, d_d;
    logic           frame_done_q, frame_done_d;
    logic [7:0]     frame_cnt_q, frame_cnt_d;

    logic           tick;
    logic           tp_end;
    logic [VW-1:0]  v_last;
    logic [HW-2:0]  x_px;
    logic [15:0]    pixel;

    // Next-state logic. Everything except the pclk divider only moves on a
    // pclk falling edge (tp_end), where the registered bus outputs are
    // recomputed for the tp that starts there. h/v/state describe that tp.
    always_comb begin
        state_d      = state_q;
        div_d        = div_q;
        pclk_d       = pclk_q;
        h_d          = h_q;
        v_d          = v_q;
        bar_px_d     = bar_px_q;
        bar_idx_d    = bar_idx_q;
        pat_d        = pat_q;
        vsync_d      = vsync_q;
        href_d       = href_q;
        d_d          = d_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        x_px         = '0;
        pixel        = 16'h0000;

        tick   = (div_q == DIV_LAST);
        tp_end = tick & pclk_q;
        div_d  = tick ? '0 : div_q + DW'(1);
        pclk_d = tick ? ~pclk_q : pclk_q;

        case (state_q)
            ST_VSYNC:  v_last = VW'(V_SYNC - 1);
            ST_VBACK:  v_last = VW'(V_BACK - 1);
            ST_ACTIVE: v_last = VW'(V_ACTIVE - 1);
            ST_VFRONT: v_last = VW'(V_FRONT - 1);
            default:   v_last = '0;
        endcase

        if (tp_end) begin
            if (state_q == ST_IDLE) begin
                if (enable) begin
                    state_d = ST_VSYNC;
                    pat_d   = pattern_sel;
                end
            end else if (h_q != H_LAST) begin
                h_d = h_q + HW'(1);
            end else begin
                h_d = '0;
                if (v_q != v_last) begin
                    v_d = v_q + VW'(1);
                end else begin
                    v_d = '0;
                    case (state_q)
                        ST_VSYNC:  state_d = ST_VBACK;
                        ST_VBACK:  state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFRONT;
                        ST_VFRONT: begin
                            frame_done_d = 1'b1;
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            // Back-to-back frames: the next vsync starts on
                            // the very edge that ends this frame.
                            if (enable) begin
                                state_d = ST_VSYNC;
                                pat_d   = pattern_sel;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end

            // Bar position follows the pixel index with a small counter so
            // no divider is needed; a new pixel begins on every even tp.
            if (h_d == '0) begin
                bar_px_d  = '0;
                bar_idx_d = 3'd0;
            end else if (!h_d[0]) begin
                if (bar_px_q == BAR_LAST) begin
                    bar_px_d  = '0;
                    bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_px_d  = bar_px_q + BW'(1);
                end
            end

            x_px = h_d[HW-1:1];
            case (pat_d)
                2'd0: begin
                    case (bar_idx_d)
                        3'd0:    pixel = 16'hFFFF;
                        3'd1:    pixel = 16'hFFE0;
                        3'd2:    pixel = 16'h07FF;
                        3'd3:    pixel = 16'h07E0;
                        3'd4:    pixel = 16'hF81F;
                        3'd5:    pixel = 16'hF800;
                        3'd6:    pixel = 16'h001F;
                        default: pixel = 16'h0000;
                    endcase
                end
                2'd1:    pixel = 16'(x_px);
                2'd2:    pixel = {frame_cnt_d, frame_cnt_d};
                default: pixel = (x_px[3] ^ v_d[3]) ? 16'hFFFF : 16'h0000;
            endcase

            vsync_d = (state_d == ST_VSYNC);
            href_d  = (state_d == ST_ACTIVE) && (h_d < H_HREF);
            d_d     = href_d ? (h_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
        end
    end

    // State register; reset is asynchronous so outputs clear without a clock.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            pclk_q       <= 1'b0;
            h_q          <= '0;
            v_q          <= '0;
            bar_px_q     <= '0;
            bar_idx_q    <= 3'd0;
            pat_q        <= 2'd0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            d_q          <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            pclk_q       <= pclk_d;
            h_q          <= h_d;
            v_q          <= v_d;
            bar_px_q     <= bar_px_d;
            bar_idx_q    <= bar_idx_d;
            pat_q        <= pat_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            d_q          <= d_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign cam.pclk   = pclk_q;
    assign cam.vsync  = vsync_q;
    assign cam.href   = href_q;
    assign cam.d      = d_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
